// File: rtl/decode_stage.sv
// RV32IM decode stage: combinational field/immediate decode into one registered
// output beat with a 1-entry skid buffer behind a valid/ready handshake.
module decode_stage #(
    parameter int unsigned PC_W       = 32,
    parameter bit          HAS_MULDIV = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_class,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic [PC_W-1:0] out_pc
);

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,  C_LUI    = 4'd1,  C_AUIPC  = 4'd2,  C_JAL    = 4'd3,
        C_JALR    = 4'd4,  C_BRANCH = 4'd5,  C_LOAD   = 4'd6,  C_STORE  = 4'd7,
        C_OPIMM   = 4'd8,  C_OP     = 4'd9,  C_MULDIV = 4'd10, C_SYSTEM = 4'd11,
        C_FENCE   = 4'd12
    } cls_e;

    typedef struct packed {
        cls_e            cls;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
    } beat_t;

    beat_t dec;
    beat_t out_q;
    beat_t skid_q;
    logic  skid_full;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

    // Illegal encodings leave cls/imm at their defaults; every legal opcode ends in 2'b11.
    always_comb begin
        dec        = '0;
        dec.cls    = C_ILLEGAL;
        dec.funct3 = f3;
        dec.alt    = in_instr[30];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.pc     = in_pc;
        case (opcode)
            7'b0110111: begin dec.cls = C_LUI;   dec.imm = imm_u; end
            7'b0010111: begin dec.cls = C_AUIPC; dec.imm = imm_u; end
            7'b1101111: begin dec.cls = C_JAL;   dec.imm = imm_j; end
            7'b1100111: if (f3 == 3'd0) begin dec.cls = C_JALR; dec.imm = imm_i; end
            7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) begin
                dec.cls = C_BRANCH; dec.imm = imm_b;
            end
            7'b0000011: if (f3 != 3'd3 && f3 < 3'd6) begin dec.cls = C_LOAD; dec.imm = imm_i; end
            7'b0100011: if (f3 <= 3'd2) begin dec.cls = C_STORE; dec.imm = imm_s; end
            7'b0010011: begin
                if ((f3 == 3'd1 && f7 == 7'h00) ||
                    (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)) ||
                    (f3 != 3'd1 && f3 != 3'd5)) begin
                    dec.cls = C_OPIMM; dec.imm = imm_i;
                end
            end
            7'b0110011: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                    dec.cls = C_OP;
                else if (f7 == 7'h01 && HAS_MULDIV)
                    dec.cls = C_MULDIV;
            end
            7'b1110011: if (f3 != 3'd4) begin dec.cls = C_SYSTEM; dec.imm = imm_i; end
            7'b0001111: begin dec.cls = C_FENCE; dec.imm = imm_i; end
            default: ;
        endcase
        if (dec.cls == C_BRANCH || dec.cls == C_STORE || dec.cls == C_FENCE ||
            dec.cls == C_ILLEGAL)
            dec.rd = '0;
        else
            dec.rd = in_instr[11:7];
    end

    logic accept, load_out;
    assign in_ready = !skid_full;
    assign accept   = in_valid && in_ready;
    assign load_out = !out_valid || out_ready;

    // Skid and input are never both live sources: accept is blocked while skid_full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (load_out) begin
            if (skid_full) begin
                out_q     <= skid_q;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_q <= dec;
            end
        end else if (accept) begin
            skid_q    <= dec;
            skid_full <= 1'b1;
        end
    end

    assign out_class  = out_q.cls;
    assign out_funct3 = out_q.funct3;
    assign out_alt    = out_q.alt;
    assign out_rd     = out_q.rd;
    assign out_rs1    = out_q.rs1;
    assign out_rs2    = out_q.rs2;
    assign out_imm    = out_q.imm;
    assign out_pc     = out_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table, stall/skid ordering,
// flush and asynchronous reset corner cases, plus a HAS_MULDIV=0 instance.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_alt;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc;

    logic        nm_in_ready, nm_out_valid, nm_out_alt;
    logic [3:0]  nm_out_class;
    logic [2:0]  nm_out_funct3;
    logic [4:0]  nm_out_rd, nm_out_rs1, nm_out_rs2;
    logic [31:0] nm_out_imm, nm_out_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.PC_W(32), .HAS_MULDIV(1'b1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_funct3(out_funct3), .out_alt(out_alt), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc)
    );

    decode_stage #(.PC_W(32), .HAS_MULDIV(1'b0)) dut_nomd (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(nm_out_valid), .out_ready(out_ready), .out_class(nm_out_class),
        .out_funct3(nm_out_funct3), .out_alt(nm_out_alt), .out_rd(nm_out_rd),
        .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2), .out_imm(nm_out_imm), .out_pc(nm_out_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] addi(input int k);
        return {12'(k + 1), 5'd0, 3'd0, 5'(k + 1), 7'h13};
    endfunction

    vec_t vecs[18];
    int   sent, got;
    logic stalled_prev;
    logic [31:0] hold_pc, hold_imm;
    logic [3:0]  hold_cls;

    initial begin
        //          instr         cls    f3    alt   rd     rs1    rs2    imm
        vecs[0]  = '{32'hFFF10093, 4'd8,  3'd0, 1'b1, 5'd1,  5'd2,  5'd31, 32'hFFFFFFFF};
        vecs[1]  = '{32'h123452B7, 4'd1,  3'd5, 1'b0, 5'd5,  5'd8,  5'd3,  32'h12345000};
        vecs[2]  = '{32'h022081B3, 4'd10, 3'd0, 1'b0, 5'd3,  5'd1,  5'd2,  32'h00000000};
        vecs[3]  = '{32'hFE000E63, 4'd5,  3'd0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFF7FC};
        vecs[4]  = '{32'hFE000EE3, 4'd5,  3'd0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFC};
        vecs[5]  = '{32'h00000000, 4'd0,  3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000};
        vecs[6]  = '{32'hFFFFFFFF, 4'd0,  3'd7, 1'b1, 5'd0,  5'd31, 5'd31, 32'h00000000};
        vecs[7]  = '{32'h40315093, 4'd8,  3'd5, 1'b1, 5'd1,  5'd2,  5'd3,  32'h00000403};
        vecs[8]  = '{32'h40311093, 4'd0,  3'd1, 1'b1, 5'd0,  5'd2,  5'd3,  32'h00000000};
        vecs[9]  = '{32'h402081B3, 4'd9,  3'd0, 1'b1, 5'd3,  5'd1,  5'd2,  32'h00000000};
        vecs[10] = '{32'h402091B3, 4'd0,  3'd1, 1'b1, 5'd0,  5'd1,  5'd2,  32'h00000000};
        vecs[11] = '{32'h008000EF, 4'd3,  3'd0, 1'b0, 5'd1,  5'd0,  5'd8,  32'h00000008};
        vecs[12] = '{32'hFE20AE23, 4'd7,  3'd2, 1'b1, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC};
        vecs[13] = '{32'hFE20BE23, 4'd0,  3'd3, 1'b1, 5'd0,  5'd1,  5'd2,  32'h00000000};
        vecs[14] = '{32'h80000397, 4'd2,  3'd0, 1'b0, 5'd7,  5'd0,  5'd0,  32'h80000000};
        vecs[15] = '{32'h00001067, 4'd0,  3'd1, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000};
        vecs[16] = '{32'h00000073, 4'd11, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000};
        vecs[17] = '{32'h00004073, 4'd0,  3'd4, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        rstn = 1'b1;

        // Decode table, one beat at a time, latency 1
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_instr  = vecs[i].instr;
            in_pc     = 32'h10 + 32'(i) * 4;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_class", i), 32'(out_class), 32'(vecs[i].cls));
            check($sformatf("v%0d_funct3", i), 32'(out_funct3), 32'(vecs[i].f3));
            check($sformatf("v%0d_alt", i), 32'(out_alt), 32'(vecs[i].alt));
            check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_rs1", i), 32'(out_rs1), 32'(vecs[i].rs1));
            check($sformatf("v%0d_rs2", i), 32'(out_rs2), 32'(vecs[i].rs2));
            check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d_pc", i), out_pc, 32'h10 + 32'(i) * 4);
            check($sformatf("v%0d_nomd_class", i), 32'(nm_out_class),
                  (vecs[i].cls == 4'd10) ? 32'd0 : 32'(vecs[i].cls));
        end

        // Stream 4 words with out_ready low in cycles 2..4
        sent = 0; got = 0; stalled_prev = 1'b0;
        hold_pc = '0; hold_imm = '0; hold_cls = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            if (stalled_prev) begin
                check("stall_hold_pc", out_pc, hold_pc);
                check("stall_hold_imm", out_imm, hold_imm);
                check("stall_hold_class", 32'(out_class), 32'(hold_cls));
            end
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (sent < 4);
            in_instr  = addi(sent);
            in_pc     = 32'h40 + 32'(sent);
            if (c == 3) check("skid_in_ready_low", 32'(in_ready), 32'd0);
            if (c == 5) check("skid_in_ready_drain", 32'(in_ready), 32'd0);
            if (c == 6) check("skid_in_ready_back", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                check("order_pc", out_pc, 32'h40 + 32'(got));
                check("order_imm", out_imm, 32'(got + 1));
                check("order_rd", 32'(out_rd), 32'(got + 1));
                got++;
            end
            stalled_prev = out_valid && !out_ready;
            hold_pc  = out_pc;
            hold_imm = out_imm;
            hold_cls = out_class;
            if (in_valid && in_ready) sent++;
        end
        check("stream_count", 32'(got), 32'd4);
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_no_dup", 32'(out_valid), 32'd0);

        // Flush with output reg and skid both full
        out_ready = 1'b0; in_valid = 1'b1; in_instr = addi(10); in_pc = 32'h80;
        @(negedge clk);
        in_instr = addi(11); in_pc = 32'h81;
        @(negedge clk);
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        check("flush_pre_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("flush_no_stale", 32'(out_valid), 32'd0);
        // Input offered during flush is dropped
        in_valid = 1'b1; in_instr = addi(12); in_pc = 32'h90; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drop_input", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("flush_drop_later", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0; in_valid = 1'b1; in_instr = addi(20); in_pc = 32'hA0;
        @(negedge clk);
        in_instr = addi(21); in_pc = 32'hA1;
        @(negedge clk);
        in_valid = 1'b0;
        check("arst_pre_in_ready", 32'(in_ready), 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_pc", out_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("arst_after_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
